// File: rtl/fpm_mul.sv
// Pipelined binary32 multiplier (flush-to-zero, round-to-nearest-even), result 3 cycles after sampling.
// Define FPM_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module fpm_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
`ifdef FPM_FLAGS_EN
    output logic [3:0]  flags,
`endif
    output logic [31:0] c
);
    localparam logic [1:0] SP_NUM  = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    logic [3:0]  vld_q;
    logic [31:0] a_q, b_q;

    // Stage 1: unpack and classify
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [1:0]  s1_sp_d;
    logic signed [9:0] s1_exp_d;

    always_comb begin
        ea = a_q[30:23];
        eb = b_q[30:23];
        fa = a_q[22:0];
        fb = b_q[22:0];
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        // Exponent 0 covers both zero and subnormal: subnormals are flushed to zero.
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        s1_exp_d = {2'b00, ea} + {2'b00, eb} - 10'd127;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
            s1_sp_d = SP_NAN;
        else if (a_inf | b_inf)
            s1_sp_d = SP_INF;
        else if (a_zero | b_zero)
            s1_sp_d = SP_ZERO;
        else
            s1_sp_d = SP_NUM;
    end

    logic              s1_sign_q, s2_sign_q;
    logic signed [9:0] s1_exp_q, s2_exp_q;
    logic [23:0]       s1_ma_q, s1_mb_q;
    logic [1:0]        s1_sp_q, s2_sp_q;
    logic [47:0]       s2_prod_q;
    logic [31:0]       c_q;

    // Stage 3: normalise, round, pack
    logic [22:0]       frac_pre, frac_r;
    logic              g, r, s, round_up, carry, ovf, unf;
    logic signed [9:0] e_fin;
    logic [31:0]       c_d;

    always_comb begin
        frac_pre = s2_prod_q[47] ? s2_prod_q[46:24] : s2_prod_q[45:23];
        g        = s2_prod_q[47] ? s2_prod_q[23]    : s2_prod_q[22];
        r        = s2_prod_q[47] ? s2_prod_q[22]    : s2_prod_q[21];
        s        = s2_prod_q[47] ? (|s2_prod_q[21:0]) : (|s2_prod_q[20:0]);
        round_up = g & (r | s | frac_pre[0]);
        // A carry out of the fraction leaves it all-zero, i.e. 1.0 at the next exponent.
        {carry, frac_r} = {1'b0, frac_pre} + {23'd0, round_up};
        e_fin = s2_exp_q + {9'd0, s2_prod_q[47]} + {9'd0, carry};
        ovf = (e_fin >= 10'sd255);
        unf = (e_fin <= 10'sd0);
        c_d = {s2_sign_q, 31'd0};
        case (s2_sp_q)
            SP_NAN:  c_d = 32'h7FC00000;
            SP_INF:  c_d = {s2_sign_q, 8'hFF, 23'd0};
            SP_ZERO: c_d = {s2_sign_q, 31'd0};
            default: begin
                if (ovf)      c_d = {s2_sign_q, 8'hFF, 23'd0};
                else if (unf) c_d = {s2_sign_q, 31'd0};
                else          c_d = {s2_sign_q, e_fin[7:0], frac_r};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= 4'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= 10'sd0;
            s1_ma_q   <= 24'd0;
            s1_mb_q   <= 24'd0;
            s1_sp_q   <= SP_NUM;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= 10'sd0;
            s2_sp_q   <= SP_NUM;
            s2_prod_q <= 48'd0;
            c_q       <= 32'd0;
        end else begin
            vld_q     <= {vld_q[2:0], in_valid};
            a_q       <= a;
            b_q       <= b;
            s1_sign_q <= a_q[31] ^ b_q[31];
            s1_exp_q  <= s1_exp_d;
            s1_ma_q   <= {1'b1, fa};
            s1_mb_q   <= {1'b1, fb};
            s1_sp_q   <= s1_sp_d;
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_exp_q;
            s2_sp_q   <= s1_sp_q;
            s2_prod_q <= s1_ma_q * s1_mb_q;
            if (vld_q[2])
                c_q <= c_d;
        end
    end

    assign out_valid = vld_q[3];
    assign c         = c_q;

`ifdef FPM_FLAGS_EN
    logic [3:0] flags_d, flags_q;

    always_comb begin
        case (s2_sp_q)
            SP_NAN:  flags_d = 4'b1000;
            SP_NUM:  flags_d = {1'b0, ovf, unf, g | r | s | ovf | unf};
            default: flags_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= 4'd0;
        else if (vld_q[2])
            flags_q <= flags_d;
    end

    assign flags = flags_q;
`endif
endmodule

// File: tb/tb_fpm_mul.sv
// Scoreboard bench for fpm_mul: randomized and directed operands against an integer-arithmetic
// reference model; checks value, latency, flags (when FPM_FLAGS_EN) and async reset behaviour.
module tb_fpm_mul;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] c;
`ifdef FPM_FLAGS_EN
    logic [3:0]  flags;
`endif

    fpm_mul dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid),
`ifdef FPM_FLAGS_EN
        .flags(flags),
`endif
        .c(c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] a, b, c;
        logic [3:0]  f;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference: exact integer product, then round-half-even by remainder comparison.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic sgn;
        int ex, ey, e, sh;
        logic [22:0] fx, fy;
        logic xn, yn, xi, yi, xz, yz;
        longint unsigned p, m, rem, half;
        logic [31:0] inf_w, zero_w;
        sgn = x[31] ^ y[31];
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        fx = x[22:0]; fy = y[22:0];
        xn = (ex == 255) && (fx != 0); yn = (ey == 255) && (fy != 0);
        xi = (ex == 255) && (fx == 0); yi = (ey == 255) && (fy == 0);
        xz = (ex == 0); yz = (ey == 0);
        inf_w  = {sgn, 8'hFF, 23'd0};
        zero_w = {sgn, 31'd0};
        if (xn || yn) return {4'b1000, 32'h7FC00000};
        if ((xi && yz) || (yi && xz)) return {4'b1000, 32'h7FC00000};
        if (xi || yi) return {4'b0000, inf_w};
        if (xz || yz) return {4'b0000, zero_w};
        p = (longint'(fx) + 64'd8388608) * (longint'(fy) + 64'd8388608);
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e = ex + ey - 127 + (sh - 23);
        m = p >> sh;
        rem = p - (m << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && m[0])) m++;
        if (m == (64'd1 << 24)) begin m = m >> 1; e++; end
        if (e >= 255) return {4'b0101, inf_w};
        if (e <= 0)   return {4'b0011, zero_w};
        return {3'b000, rem != 0, sgn, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] t;
        logic [7:0]  e;
        logic [22:0] f;
        t = $urandom;
        f = t[22:0];
        case ($urandom_range(0, 15))
            0:       begin e = 8'd0; if (t[31]) f = 23'd0; end
            1:       begin e = 8'hFF; f = 23'd0; end
            2:       begin e = 8'hFF; f[0] = 1'b1; end
            3:       e = 8'($urandom_range(190, 254));
            4:       e = 8'($urandom_range(1, 60));
            5:       begin e = 8'($urandom_range(100, 154)); f[22:8] = 15'h7FFF; end
            default: e = 8'($urandom_range(90, 164));
        endcase
        return {t[30], e, f};
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        exp_t ex;
        logic [35:0] r;
        r = model(x, y);
        ex.a = x; ex.b = y; ex.c = r[31:0]; ex.f = r[35:32]; ex.cyc = cyc + 4;
        sb.push_back(ex);
        in_valid = 1'b1; a = x; b = y;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out c=%h (no result pending)", c);
            end else begin
                exp_t ex;
                ex = sb.pop_front();
                if (c !== ex.c) begin
                    bad++;
                    $display("FAIL product a=%h b=%h got=%h want=%h", ex.a, ex.b, c, ex.c);
                end
                total++;
                if (cyc != ex.cyc) begin
                    bad++;
                    $display("FAIL latency a=%h b=%h got_cyc=%0d want_cyc=%0d", ex.a, ex.b, cyc, ex.cyc);
                end
`ifdef FPM_FLAGS_EN
                total++;
                if (flags !== ex.f) begin
                    bad++;
                    $display("FAIL flags a=%h b=%h got=%b want=%b", ex.a, ex.b, flags, ex.f);
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
        #3;
        total++;
        if (out_valid !== 1'b0 || c !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got ov=%b c=%h want ov=0 c=0", out_valid, c);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(32'h3FC00000, 32'h3F400000);
        issue(32'h3F980000, 32'h3F100000);
        issue(32'h3F800001, 32'h3F800001);
        issue(32'hC0000000, 32'h40400000);
        issue(32'h7F000000, 32'h40000000);
        issue(32'h7F800000, 32'h00000000);
        issue(32'h7FC00001, 32'h3F800000);
        issue(32'h00800000, 32'h00800000);
        issue(32'h80400000, 32'h3F800000);
        issue(32'hFF800000, 32'h3F800000);
        issue(32'h3FFFFFFF, 32'h3FFFFFFF);
        issue(32'h80000000, 32'h7F800000);
        idle();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue(rnd_op(), rnd_op());
        end
        repeat (5) idle();

        // Three ops in flight, then an asynchronous reset mid-cycle.
        issue(32'h3FC00000, 32'h3F400000);
        issue(32'h40000000, 32'h40000000);
        issue(32'h40400000, 32'h40400000);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        sb.delete();
        #1;
        total++;
        if (out_valid !== 1'b0 || c !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got ov=%b c=%h want ov=0 c=0", out_valid, c);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) idle();
        issue(32'h40A00000, 32'hC0000000);
        issue(32'h3F800000, 32'h3F800000);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
